dsp_mult_selftest: RTL and testbench



---
 rtl/dsp_mult_selftest_pkg.sv | 22 ++
 rtl/dsp_mult_selftest_if.sv | 12 +
 rtl/dsp_mult_pipe.sv | 35 +++
 rtl/dsp_mult_selftest.sv | 130 +++++++++++++
 tb/tb_dsp_mult_selftest.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/dsp_mult_selftest_pkg.sv
// dsp_mult_selftest_pkg: FSM state encoding, LFSR tap mask, default seed
// and the shared LFSR step function for the multiplier self-test.
package dsp_mult_selftest_pkg;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_RUN,
        ST_CHECK,
        ST_PASS,
        ST_FAIL
    } state_e;

    // x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Fibonacci step: shift left, parity of tapped bits into bit0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/dsp_mult_selftest_if.sv
// dsp_mult_selftest_if: status bundle of the self-test.
// correct/done/fail: driven by master (the self-test), read by slave.
interface dsp_mult_selftest_if;

    logic correct;
    logic done;
    logic fail;

    modport master (output correct, output done, output fail);
    modport slave  (input  correct, input  done, input  fail);

endinterface

// File: rtl/dsp_mult_pipe.sv
// dsp_mult_pipe: 2-stage registered unsigned WIDTH x WIDTH multiplier.
// Ports: clk, rst_n (async low), a, b (WIDTH) in; p (2*WIDTH) out, 2 cycles.
module dsp_mult_pipe
    import dsp_mult_selftest_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p
);

    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] p_q;

    // Input and output registers around a bare multiply so the
    // whole structure folds into the MAC block's pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            p_q <= '0;
        end else begin
            a_q <= a;
            b_q <= b;
            p_q <= {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        end
    end

    assign p = p_q;

endmodule

// File: rtl/dsp_mult_selftest.sv
// dsp_mult_selftest: LFSR operands checked on fast vs shift-add multiplier.
// Ports: clk, rst_n (async low); st.master drives correct/done/fail (sticky).
// Option: SELFTEST_FAULT_INJECT_EN flips fast product bit0 at test 5.
module dsp_mult_selftest
    import dsp_mult_selftest_pkg::*;
#(
    parameter int          WIDTH     = 16,
    parameter int          NUM_TESTS = 256,
    parameter logic [15:0] SEED      = DEFAULT_SEED
) (
    input  logic                clk,
    input  logic                rst_n,
    dsp_mult_selftest_if.master st
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int TW = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1;

    state_e state_q, state_d;

    logic [15:0]      lfsr_a_q, lfsr_b_q;
    logic [TW-1:0]    test_q;
    logic [CW-1:0]    bit_q;
    logic [WIDTH-1:0] op_a_q, op_b_q;
    logic [WIDTH-1:0] mplier_q;
    logic [PW-1:0]    mcand_q, acc_q;

    logic [WIDTH-1:0] load_a, load_b;
    logic [WIDTH-1:0] pipe_a, pipe_b;
    logic [PW-1:0]    fast_p, fast_cmp;
    logic             last_bit, last_test, match;

    assign load_a = WIDTH'(lfsr_a_q);
    assign load_b = WIDTH'(lfsr_b_q);

    // The LFSRs step at LOAD, so the pipe sees the live LFSR value
    // during LOAD and the held copy afterwards.
    assign pipe_a = (state_q == ST_LOAD) ? load_a : op_a_q;
    assign pipe_b = (state_q == ST_LOAD) ? load_b : op_b_q;

    dsp_mult_pipe #(
        .WIDTH (WIDTH)
    ) u_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (pipe_a),
        .b     (pipe_b),
        .p     (fast_p)
    );

`ifdef SELFTEST_FAULT_INJECT_EN
    assign fast_cmp = {fast_p[PW-1:1],
                       fast_p[0] ^ (32'(test_q) == 32'd5)};
`else
    assign fast_cmp = fast_p;
`endif

    assign last_bit  = (bit_q == CW'(WIDTH - 1));
    assign last_test = (test_q == TW'(NUM_TESTS - 1));
    assign match     = (fast_cmp == acc_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_LOAD:  state_d = ST_RUN;
            ST_RUN:   if (last_bit) state_d = ST_CHECK;
            ST_CHECK: begin
                if (!match)         state_d = ST_FAIL;
                else if (last_test) state_d = ST_PASS;
                else                state_d = ST_LOAD;
            end
            ST_PASS:  state_d = ST_PASS;
            ST_FAIL:  state_d = ST_FAIL;
            default:  state_d = ST_LOAD;
        endcase
    end

    // Reference: one multiplier bit per RUN cycle, LSB first,
    // multiplicand pre-shifted so no barrel shifter is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_a_q <= SEED;
            lfsr_b_q <= ~SEED;
            test_q   <= '0;
            bit_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            mplier_q <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
        end else begin
            unique case (state_q)
                ST_LOAD: begin
                    op_a_q   <= load_a;
                    op_b_q   <= load_b;
                    mcand_q  <= {{WIDTH{1'b0}}, load_a};
                    mplier_q <= load_b;
                    acc_q    <= '0;
                    bit_q    <= '0;
                    lfsr_a_q <= lfsr_step(lfsr_a_q);
                    lfsr_b_q <= lfsr_step(lfsr_b_q);
                end
                ST_RUN: begin
                    if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    bit_q    <= bit_q + 1'b1;
                end
                ST_CHECK: begin
                    if (match && !last_test) test_q <= test_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign st.correct = (state_q == ST_PASS);
    assign st.fail    = (state_q == ST_FAIL);
    assign st.done    = (state_q == ST_PASS) || (state_q == ST_FAIL);

endmodule

// File: tb/tb_dsp_mult_selftest.sv
// tb_dsp_mult_selftest: directed checks of dsp_mult_selftest (default and
// NUM_TESTS=4 builds) and of dsp_mult_pipe on its own.
module tb_dsp_mult_selftest;

    logic clk = 1'b0;
    logic rst_n;
    logic pipe_rst_n;
    logic [15:0] pa, pb;
    logic [31:0] pp;
    int cyc;
    int n_cmp = 0;
    int n_bad = 0;

`ifdef SELFTEST_FAULT_INJECT_EN
    localparam logic EXP_OK = 1'b0;
`else
    localparam logic EXP_OK = 1'b1;
`endif

    always #5 clk = ~clk;

    dsp_mult_selftest_if st ();
    dsp_mult_selftest_if st4 ();

    dsp_mult_selftest dut (
        .clk   (clk),
        .rst_n (rst_n),
        .st    (st.master)
    );

    dsp_mult_selftest #(
        .WIDTH     (16),
        .NUM_TESTS (4)
    ) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .st    (st4.master)
    );

    dsp_mult_pipe #(
        .WIDTH (16)
    ) u_pipe (
        .clk   (clk),
        .rst_n (pipe_rst_n),
        .a     (pa),
        .b     (pb),
        .p     (pp)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after posedge number e since release.
    task automatic go(input int e);
        while (cyc < e) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    always @(negedge clk) begin
        assert (!(st.correct && st.fail))
            else $error("main: correct and fail both high");
        assert (st.done || !(st.correct || st.fail))
            else $error("main: status without done");
        assert (!(st4.correct && st4.fail))
            else $error("n4: correct and fail both high");
        assert (st4.done || !(st4.correct || st4.fail))
            else $error("n4: status without done");
    end

    task automatic final_checks(input string tag);
        go(4607);
        chk({tag, " done pre"}, st.done, !EXP_OK);
        chk({tag, " correct pre"}, st.correct, 1'b0);
        go(4608);
        chk({tag, " done"}, st.done, 1'b1);
        chk({tag, " correct"}, st.correct, EXP_OK);
        chk({tag, " fail"}, st.fail, !EXP_OK);
    endtask

    initial begin
        int bad;
        rst_n = 1'b0;
        pipe_rst_n = 1'b0;
        pa = '0;
        pb = '0;
        cyc = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst correct", st.correct, 1'b0);
        chk("rst done", st.done, 1'b0);
        chk("rst fail", st.fail, 1'b0);
        chk("rst n4 done", st4.done, 1'b0);
        chk("rst lfsr_a", dut.lfsr_a_q, 16'hACE1);
        chk("rst lfsr_b", dut.lfsr_b_q, 16'h531E);
        chk("rst pipe p", pp, 32'h0);

        // pipe: back-to-back vectors, 2-cycle latency
        @(negedge clk);
        pipe_rst_n = 1'b1;
        pa = 16'hFFFF; pb = 16'hFFFF;
        @(negedge clk);
        chk("pipe lat1", pp, 32'h0);
        pa = 16'd3; pb = 16'd5;
        @(negedge clk);
        chk("pipe ffff", pp, 32'hFFFE0001);
        pa = 16'h0; pb = 16'h1234;
        @(negedge clk);
        chk("pipe 3x5", pp, 32'd15);
        @(negedge clk);
        chk("pipe 0x1234", pp, 32'h0);

        // run 1: release at a negedge, edge 1 is the next posedge
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        go(1);
        chk("n4 A0", dut4.op_a_q, 16'hACE1);
        chk("n4 B0", dut4.op_b_q, 16'h531E);
        go(19);
        chk("n4 A1", dut4.op_a_q, 16'h59C3);
        chk("n4 B1", dut4.op_b_q, 16'hA63D);
        go(71);
        chk("n4 done pre", st4.done, 1'b0);
        go(72);
        chk("n4 done", st4.done, 1'b1);
        chk("n4 correct", st4.correct, 1'b1);
        chk("n4 fail", st4.fail, 1'b0);
`ifdef SELFTEST_FAULT_INJECT_EN
        go(107);
        chk("inj fail pre", st.fail, 1'b0);
        go(108);
        chk("inj fail", st.fail, 1'b1);
        chk("inj done", st.done, 1'b1);
        chk("inj correct", st.correct, 1'b0);
`endif
        final_checks("run1");

        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            go(cyc + 1);
            if (st.correct !== EXP_OK || st.fail !== !EXP_OK ||
                st.done !== 1'b1)
                bad++;
        end
        chk("hold cycles bad", 64'(bad), 64'd0);
        chk("n4 hold", st4.correct, 1'b1);

        // reset while terminal: outputs drop before any clock edge
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async correct", st.correct, 1'b0);
        chk("async fail", st.fail, 1'b0);
        chk("async done", st.done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;

        // run 2: pulse reset mid-run at cycle 1000
        go(1000);
        chk("mid done", st.done, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid lfsr_a", dut.lfsr_a_q, 16'hACE1);
        chk("mid state", 64'(dut.state_q), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        go(72);
        chk("n4 rerun", st4.correct, 1'b1);
        final_checks("run3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
